// File: rtl/taxi_prbs_check.sv
//==============================================================================
// Module      : taxi_prbs_check
// Description : Self-synchronising PRBS checker with lock FSM and saturating
//               error counters. The optional bit-error popcount is built only
//               when TAXI_PRBS_CHECK_BIT_CNT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module taxi_prbs_check #(
  parameter int                LFSR_W      = 31,
  parameter logic [LFSR_W-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic              LFSR_INVERT = 1'b1,
  parameter logic              REVERSE     = 1'b0,
  parameter int                DATA_W      = 32,
  parameter int                ERR_CNT_W   = 32,
  parameter int                LOCK_CNT    = 64,
  parameter int                UNLOCK_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 data_valid,
  input  logic                 cnt_clr,
  output logic [DATA_W-1:0]    err_out,
  output logic                 err_valid,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_word_cnt,
  output logic [ERR_CNT_W-1:0] err_bit_cnt
);

  localparam int c_clean_w = $clog2(LOCK_CNT + 1);
  localparam int c_bad_w   = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                r_fsm;
  state_t                w_fsm_next;
  logic [c_clean_w-1:0]  r_clean_run;
  logic [c_clean_w-1:0]  w_clean_next;
  logic [c_bad_w-1:0]    r_bad_run;
  logic [c_bad_w-1:0]    w_bad_next;

  logic [LFSR_W-1:0]     r_state;
  logic [LFSR_W-1:0]     w_state_next;
  logic [LFSR_W-1:0]     w_s;
  logic                  w_fb;
  logic [DATA_W-1:0]     w_d;
  logic [DATA_W-1:0]     w_d_ord;
  logic [DATA_W-1:0]     w_err_ord;
  logic [DATA_W-1:0]     w_err;
  logic                  w_bad;

  logic [DATA_W-1:0]     r_err;
  logic                  r_err_valid;
  logic                  r_bad;
  logic [ERR_CNT_W-1:0]  r_word_cnt;
  logic                  w_count;

  assign w_d = data_in ^ {DATA_W{LFSR_INVERT}};

  // Feed-forward Fibonacci: the received bit is shifted in, the tap XOR is the
  // prediction. Bits are processed in shift order (w_d_ord[DATA_W-1] first).
  always_comb begin
    w_d_ord   = '0;
    w_err_ord = '0;
    w_err     = '0;
    w_fb      = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      w_d_ord[i] = REVERSE ? w_d[DATA_W-1-i] : w_d[i];
    end
    w_s = r_state;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_fb = w_s[LFSR_W-1];
      for (int j = 1; j < LFSR_W; j++) begin
        if (LFSR_POLY[j]) begin
          w_fb = w_fb ^ w_s[j-1];
        end
      end
      w_err_ord[i] = w_fb ^ w_d_ord[i];
      w_s          = {w_s[LFSR_W-2:0], w_d_ord[i]};
    end
    w_state_next = w_s;
    for (int i = 0; i < DATA_W; i++) begin
      w_err[i] = REVERSE ? w_err_ord[DATA_W-1-i] : w_err_ord[i];
    end
  end

  // An all-zero state means stuck input; never treat that as clean.
  assign w_bad = (|w_err) || (w_state_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= '0;
      r_err       <= '0;
      r_err_valid <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_err_valid <= data_valid;
      if (data_valid) begin
        r_state <= w_state_next;
        r_err   <= w_err;
        r_bad   <= w_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ST_HUNT;
      r_clean_run <= '0;
      r_bad_run   <= '0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_clean_run <= w_clean_next;
      r_bad_run   <= w_bad_next;
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_clean_next = r_clean_run;
    w_bad_next   = r_bad_run;
    if (r_err_valid) begin
      case (r_fsm)
        ST_HUNT: begin
          if (r_bad) begin
            w_clean_next = '0;
          end else if (r_clean_run == c_clean_w'(LOCK_CNT - 1)) begin
            w_fsm_next   = ST_LOCK;
            w_clean_next = '0;
            w_bad_next   = '0;
          end else begin
            w_clean_next = r_clean_run + c_clean_w'(1);
          end
        end
        ST_LOCK: begin
          if (!r_bad) begin
            w_bad_next = '0;
          end else if (r_bad_run == c_bad_w'(UNLOCK_CNT - 1)) begin
            w_fsm_next   = ST_HUNT;
            w_clean_next = '0;
            w_bad_next   = '0;
          end else begin
            w_bad_next = r_bad_run + c_bad_w'(1);
          end
        end
        default: begin
          w_fsm_next   = ST_HUNT;
          w_clean_next = '0;
          w_bad_next   = '0;
        end
      endcase
    end
  end

  // Only words evaluated while locked are counted, including the one that unlocks.
  assign w_count = r_err_valid && r_bad && (r_fsm == ST_LOCK);

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_word_cnt <= '0;
    end else if (w_count && !(&r_word_cnt)) begin
      r_word_cnt <= r_word_cnt + ERR_CNT_W'(1);
    end
  end

`ifdef TAXI_PRBS_CHECK_BIT_CNT_EN
  localparam int c_pop_w = $clog2(DATA_W + 1);
  localparam int c_sum_w = ((ERR_CNT_W > c_pop_w) ? ERR_CNT_W : c_pop_w) + 1;
  localparam logic [ERR_CNT_W-1:0] c_cnt_max = '1;

  logic [c_pop_w-1:0]   w_pop;
  logic [c_pop_w-1:0]   r_pop;
  logic [c_sum_w-1:0]   w_bit_sum;
  logic [ERR_CNT_W-1:0] r_bit_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_pop = w_pop + c_pop_w'(w_err[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop <= '0;
    end else if (data_valid) begin
      r_pop <= w_pop;
    end
  end

  assign w_bit_sum = c_sum_w'(r_bit_cnt) + c_sum_w'(r_pop);

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_bit_cnt <= '0;
    end else if (w_count) begin
      if (w_bit_sum > c_sum_w'(c_cnt_max)) begin
        r_bit_cnt <= c_cnt_max;
      end else begin
        r_bit_cnt <= w_bit_sum[ERR_CNT_W-1:0];
      end
    end
  end

  assign err_bit_cnt = r_bit_cnt;
`else
  assign err_bit_cnt = '0;
`endif

  assign err_out      = r_err;
  assign err_valid    = r_err_valid;
  assign locked       = (r_fsm == ST_LOCK);
  assign err_word_cnt = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_taxi_prbs_check.sv
//==============================================================================
// Module      : tb_taxi_prbs_check
// Description : Directed bench for taxi_prbs_check (PRBS31 inverted, 32-bit).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_taxi_prbs_check;

`ifdef TAXI_PRBS_CHECK_BIT_CNT_EN
  localparam logic BITCNT_ON = 1'b1;
`else
  localparam logic BITCNT_ON = 1'b0;
`endif

  localparam int NV   = 300;
  localparam int FLIP = 200;
  localparam int GARB = 220;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        cnt_clr = 1'b0;

  logic [31:0] err_out, err_word_cnt, err_bit_cnt;
  logic        err_valid, locked;
  logic [31:0] err_out2;
  logic        err_valid2, locked2;
  logic [3:0]  err_word_cnt2, err_bit_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [30:0] gen_s;

  always #5 clk = ~clk;

  taxi_prbs_check dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .cnt_clr(cnt_clr),
    .err_out(err_out), .err_valid(err_valid), .locked(locked),
    .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt)
  );

  taxi_prbs_check #(.ERR_CNT_W(4), .UNLOCK_CNT(32)) dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .cnt_clr(cnt_clr),
    .err_out(err_out2), .err_valid(err_valid2), .locked(locked2),
    .err_word_cnt(err_word_cnt2), .err_bit_cnt(err_bit_cnt2)
  );

  typedef struct {
    logic [31:0] data;
    logic        chk_err;
    logic [31:0] exp_err;
    logic        exp_locked;
    logic [31:0] exp_wcnt;
    logic        chk_bcnt;
    logic [31:0] exp_bcnt;
  } vec_t;

  vec_t tbl [NV];

  // PRBS31 generator x^31+x^28+1, MSB of the word transmitted first.
  function automatic logic [31:0] prbs_word();
    logic [31:0] w;
    logic        b;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      b     = gen_s[30] ^ gen_s[27];
      gen_s = {gen_s[29:0], b};
      w[i]  = b;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] d, input logic v, input logic c);
    data_in    = d;
    data_valid = v;
    cnt_clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    cnt_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wc;

    // Stream: clean inverted PRBS31, one flipped first bit, four garbage words.
    gen_s = 31'd1;
    for (int k = 0; k < NV; k++) begin
      tbl[k].data = ~prbs_word();
      if (k == FLIP) tbl[k].data = tbl[k].data ^ 32'h8000_0000;
      case (k)
        GARB:     tbl[k].data = 32'h1234_5678;
        GARB + 1: tbl[k].data = 32'h9ABC_DEF0;
        GARB + 2: tbl[k].data = 32'hDEAD_BEEF;
        GARB + 3: tbl[k].data = 32'h0F1E_2D3C;
        default: ;
      endcase
      tbl[k].chk_err    = (k >= 1) && !(k >= GARB && k <= GARB + 4);
      tbl[k].exp_err    = (k == FLIP) ? 32'h8000_0009 : 32'h0;
      tbl[k].exp_locked = (k >= 65 && k <= GARB + 3) || (k >= GARB + 69);
      wc = (k > FLIP) ? 1 : 0;
      if (k > GARB) wc = wc + (((k - GARB) > 4) ? 4 : (k - GARB));
      tbl[k].exp_wcnt   = 32'(wc);
      tbl[k].chk_bcnt   = !BITCNT_ON || (k <= GARB);
      tbl[k].exp_bcnt   = (BITCNT_ON && k > FLIP) ? 32'd3 : 32'd0;
    end

    do_reset();
    chk("reset err_out", err_out, 32'h0);
    chk("reset err_valid", 32'(err_valid), 32'h0);
    chk("reset locked", 32'(locked), 32'h0);
    chk("reset err_word_cnt", err_word_cnt, 32'h0);
    chk("reset err_bit_cnt", err_bit_cnt, 32'h0);

    for (int k = 0; k < NV; k++) begin
      apply(tbl[k].data, 1'b1, 1'b0);
      chk($sformatf("tbl[%0d] err_valid", k), 32'(err_valid), 32'h1);
      if (tbl[k].chk_err) chk($sformatf("tbl[%0d] err_out", k), err_out, tbl[k].exp_err);
      chk($sformatf("tbl[%0d] locked", k), 32'(locked), 32'(tbl[k].exp_locked));
      chk($sformatf("tbl[%0d] err_word_cnt", k), err_word_cnt, tbl[k].exp_wcnt);
      if (tbl[k].chk_bcnt) chk($sformatf("tbl[%0d] err_bit_cnt", k), err_bit_cnt, tbl[k].exp_bcnt);
    end

    // Stuck all-ones input from reset never locks.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      apply(32'hFFFF_FFFF, 1'b1, 1'b0);
      chk($sformatf("stuck[%0d] locked", k), 32'(locked), 32'h0);
    end
    chk("stuck err_word_cnt", err_word_cnt, 32'h0);
    chk("stuck err_bit_cnt", err_bit_cnt, 32'h0);
    chk("stuck err_out", err_out, 32'h0);

    // 4-bit counters with UNLOCK_CNT=32: saturation and clear priority.
    do_reset();
    gen_s = 31'd1;
    for (int k = 0; k < 66; k++) apply(~prbs_word(), 1'b1, 1'b0);
    chk("sat locked before errors", 32'(locked2), 32'h1);
    for (int j = 1; j <= 20; j++) begin
      apply(32'h0, 1'b1, 1'b0);
      if (j == 15) chk("sat wcnt j15", 32'(err_word_cnt2), 32'd14);
      if (j == 16) chk("sat wcnt j16", 32'(err_word_cnt2), 32'd15);
    end
    chk("sat wcnt held at max", 32'(err_word_cnt2), 32'd15);
    chk("sat bcnt at max", 32'(err_bit_cnt2), BITCNT_ON ? 32'd15 : 32'd0);
    chk("sat still locked", 32'(locked2), 32'h1);
    apply(32'h0, 1'b1, 1'b1);
    chk("clr wcnt", 32'(err_word_cnt2), 32'd0);
    chk("clr bcnt", 32'(err_bit_cnt2), 32'd0);
    apply(32'h0, 1'b1, 1'b0);
    chk("post-clr wcnt", 32'(err_word_cnt2), 32'd1);
    chk("post-clr bcnt clamp", 32'(err_bit_cnt2), BITCNT_ON ? 32'd15 : 32'd0);
    apply(32'h0, 1'b1, 1'b1);
    chk("clr beats increment", 32'(err_word_cnt2), 32'd0);
    chk("clr keeps lock", 32'(locked2), 32'h1);
    apply(32'h0, 1'b1, 1'b0);
    chk("increment after clr", 32'(err_word_cnt2), 32'd1);

    // Valid toggling every cycle, then reset mid-stream and relock.
    do_reset();
    gen_s = 31'd1;
    for (int k = 0; k <= 80; k++) begin
      apply(~prbs_word(), 1'b1, 1'b0);
      chk($sformatf("tog[%0d] err_valid", k), 32'(err_valid), 32'h1);
      if (k >= 1) chk($sformatf("tog[%0d] err_out", k), err_out, 32'h0);
      chk($sformatf("tog[%0d] locked", k), 32'(locked), 32'(k >= 65));
      apply(32'h5A5A_5A5A, 1'b0, 1'b0);
      chk($sformatf("tog[%0d] idle err_valid", k), 32'(err_valid), 32'h0);
      if (k >= 1) chk($sformatf("tog[%0d] idle err_out held", k), err_out, 32'h0);
      chk($sformatf("tog[%0d] idle locked", k), 32'(locked), 32'(k >= 64));
    end
    chk("tog err_word_cnt", err_word_cnt, 32'h0);
    chk("tog err_bit_cnt", err_bit_cnt, 32'h0);

    rst = 1'b1;
    apply(~prbs_word(), 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst locked", 32'(locked), 32'h0);
    chk("midrst err_valid", 32'(err_valid), 32'h0);
    chk("midrst err_out", err_out, 32'h0);
    chk("midrst err_word_cnt", err_word_cnt, 32'h0);
    for (int k = 0; k <= 66; k++) begin
      apply(~prbs_word(), 1'b1, 1'b0);
      if (k == 0) chk("relock first word errored", 32'(err_out != 32'h0), 32'h1);
      if (k == 64) chk("relock not yet", 32'(locked), 32'h0);
      if (k == 65) chk("relock asserted", 32'(locked), 32'h1);
    end
    chk("relock err_word_cnt", err_word_cnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
